pmem_responder: RTL and testbench

//  Memory-side end of the 128-bit line protocol that the cache arbiter drives (pmem_read/pmem_write/

---
 rtl/pmem_responder_pkg.sv | 20 ++
 rtl/pmem_responder_line_ram.sv | 31 +++
 rtl/pmem_responder.sv | 155 +++++++++++++++
 tb/tb_pmem_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_responder_pkg.sv
// Shared types for the 128-bit line memory responder: line type, FSM state
// encoding and small elaboration-time helpers.
package pmem_responder_pkg;

    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        PM_IDLE = 2'd0,
        PM_WAIT = 2'd1,
        PM_RESP = 2'd2
    } pmem_state_t;

    // Byte offset within a 16-byte line; these address bits never select a line.
    localparam int PM_OFFSET_BITS = 4;

    function automatic int pm_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pmem_responder_line_ram.sv
// Single-port line store: synchronous write, registered read with enable so
// the read data stays put between reads. Contents are never reset.
module line_ram
    import pmem_responder_pkg::*;
#(
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic [INDEX_BITS-1:0] i_addr,
    input  logic                  i_we,
    input  logic [127:0]          i_wdata,
    input  logic                  i_re,
    output logic [127:0]          o_rdata
);

    lc3b_line r_mem [2**INDEX_BITS];
    lc3b_line r_q;

    // Write a line or capture a read; the two never happen in the same cycle.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/pmem_responder.sv
// Memory-side responder for the 128-bit line protocol. Accepts one request at
// a time, waits a programmable latency, then pulses pmem_resp for one cycle.
// Writes commit as the FSM leaves RESP, so an aborted or reset request never
// touches the line store.
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int INDEX_BITS    = 8,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata,
    output logic         busy,
    output logic         proto_err,
    output logic [15:0]  req_count
);

    localparam int MAX_LAT = pm_max(READ_LATENCY, WRITE_LATENCY);
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT + 1) : 1;

    pmem_state_t           r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_is_write;
    logic [INDEX_BITS-1:0] r_index;
    logic [127:0]          r_wdata;
    logic                  r_resp;
    logic                  r_busy;
    logic                  r_err;
    logic                  r_rdata_ok;
    logic [15:0]           r_req_count;

    logic                  w_req;
    logic [INDEX_BITS-1:0] w_in_index;
    logic                  w_acc_lat1;
    logic [CNT_W-1:0]      w_acc_cnt;
    logic                  w_held;
    logic                  w_op_write;
    logic                  w_to_resp;
    logic [INDEX_BITS-1:0] w_ram_addr;
    logic                  w_ram_we;
    logic                  w_ram_re;
    logic [127:0]          w_ram_q;
    logic [15:0]           w_unused_addr;

    assign w_req         = pmem_read | pmem_write;
    assign w_in_index    = pmem_address[INDEX_BITS+PM_OFFSET_BITS-1:PM_OFFSET_BITS];
    assign w_unused_addr = pmem_address;

    // A simultaneous read+write is served as a write.
    assign w_acc_lat1 = pmem_write ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1);
    assign w_acc_cnt  = pmem_write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);

    // The latched op's own request line must stay high while waiting.
    assign w_held     = r_is_write ? pmem_write : pmem_read;
    assign w_op_write = (r_state == PM_IDLE) ? pmem_write : r_is_write;

    assign w_to_resp = ((r_state == PM_IDLE) && w_req && w_acc_lat1) ||
                       ((r_state == PM_WAIT) && w_held && (r_cnt == CNT_W'(1)));

    // In IDLE the live address feeds the RAM so a latency-1 read sees its line.
    assign w_ram_addr = (r_state == PM_IDLE) ? w_in_index : r_index;
    assign w_ram_re   = w_to_resp && !w_op_write;
    assign w_ram_we   = (r_state == PM_RESP) && r_is_write;

    line_ram #(
        .INDEX_BITS (INDEX_BITS)
    ) u_line_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_wdata (r_wdata),
        .i_re    (w_ram_re),
        .o_rdata (w_ram_q)
    );

    // Capture op, line index and write data when a request is accepted.
    always_ff @(posedge clk) begin
        if ((r_state == PM_IDLE) && w_req) begin
            r_is_write <= pmem_write;
            r_index    <= w_in_index;
            r_wdata    <= pmem_wdata;
        end
    end

    // Request FSM with latency counter, response pulse and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PM_IDLE;
            r_cnt       <= '0;
            r_resp      <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata_ok  <= 1'b0;
            r_req_count <= '0;
        end else begin
            r_resp <= 1'b0;
            if (w_ram_re) begin
                r_rdata_ok <= 1'b1;
            end
            case (r_state)
                PM_IDLE: begin
                    if (w_req) begin
                        if (pmem_read && pmem_write) begin
                            r_err <= 1'b1;
                        end
                        r_busy <= 1'b1;
                        if (w_to_resp) begin
                            r_state <= PM_RESP;
                            r_resp  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= PM_WAIT;
                            r_cnt   <= w_acc_cnt;
                        end
                    end
                end
                PM_WAIT: begin
                    if (!w_held) begin
                        r_state <= PM_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (w_to_resp) begin
                            r_state <= PM_RESP;
                            r_resp  <= 1'b1;
                        end
                    end
                end
                PM_RESP: begin
                    r_state     <= PM_IDLE;
                    r_busy      <= 1'b0;
                    r_req_count <= r_req_count + 16'd1;
                end
                default: begin
                    r_state <= PM_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_resp  = r_resp;
    assign pmem_rdata = r_rdata_ok ? w_ram_q : '0;
    assign busy       = r_busy;
    assign proto_err  = r_err;
    assign req_count  = r_req_count;

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: table of single requests scored through a queue of
// expected responses, plus hand sequences for back-to-back, reset abort,
// latency 1 and counter wrap.
module tb_pmem_responder;

    localparam int LAT = 4;
    localparam logic [127:0] D0 = 128'hDEADBEEF_01234567_89ABCDEF_0BADBEEF;
    localparam logic [127:0] D1 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] D2 = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
    localparam logic [127:0] D3 = 128'hCAFEF00D_00000000_FFFFFFFF_12345678;
    localparam logic [127:0] D4 = 128'h0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0;
    localparam logic [127:0] D5 = 128'h77777777_77777777_77777777_77777777;
    localparam logic [127:0] D6 = 128'hFEEDFACE_C0FFEE00_BAADF00D_87654321;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        int           drop;
        logic         exp_resp;
        logic [127:0] exp_rdata;
        logic         exp_err;
        logic [15:0]  exp_cnt;
    } vec_t;

    typedef struct {
        int           cyc;
        logic         chk;
        logic [127:0] data;
    } sb_t;

    logic         clk;
    logic         rst_n;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic         busy, proto_err;
    logic [15:0]  req_count;

    logic         p1_read, p1_write;
    logic [15:0]  p1_addr;
    logic [127:0] p1_wdata;
    logic         p1_resp;
    logic [127:0] p1_rdata;
    logic         p1_busy, p1_err;
    logic [15:0]  p1_cnt;

    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    sb_t  sb_q[$];
    sb_t  mon_e;
    vec_t vt[12];

    pmem_responder #(
        .INDEX_BITS (8), .READ_LATENCY (LAT), .WRITE_LATENCY (LAT)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .pmem_read (pmem_read), .pmem_write (pmem_write),
        .pmem_address (pmem_address), .pmem_wdata (pmem_wdata),
        .pmem_resp (pmem_resp), .pmem_rdata (pmem_rdata),
        .busy (busy), .proto_err (proto_err), .req_count (req_count)
    );

    pmem_responder #(
        .INDEX_BITS (8), .READ_LATENCY (1), .WRITE_LATENCY (1)
    ) dut1 (
        .clk (clk), .rst_n (rst_n),
        .pmem_read (p1_read), .pmem_write (p1_write),
        .pmem_address (p1_addr), .pmem_wdata (p1_wdata),
        .pmem_resp (p1_resp), .pmem_rdata (p1_rdata),
        .busy (p1_busy), .proto_err (p1_err), .req_count (p1_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got running want finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: every response must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && pmem_resp) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp at cycle %0d want none", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_cycle", 128'(cyc), 128'(mon_e.cyc));
                if (mon_e.chk) chk("rdata", pmem_rdata, mon_e.data);
            end
        end
    end

    // Drive one request from the table; called on a falling edge.
    task automatic apply(input vec_t v, input string nm);
        int c0;
        bit done;
        pmem_read    = v.rd;
        pmem_write   = v.wr;
        pmem_address = v.addr;
        pmem_wdata   = v.wdata;
        c0 = cyc;
        if (v.exp_resp) sb_q.push_back('{c0 + LAT, v.rd && !v.wr, v.exp_rdata});
        done = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                pmem_address = v.addr ^ 16'h0100;
                pmem_wdata   = ~v.wdata;
            end
            if (v.drop == k) begin
                chk({nm, "_busy_before_drop"}, 128'(busy), 128'(1));
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
                @(negedge clk);
                chk({nm, "_busy_after_drop"}, 128'(busy), 128'(0));
                done = 1'b1;
            end else if (pmem_resp) begin
                @(negedge clk);
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: got no resp want resp within 20 cycles", nm);
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
        end
        chk({nm, "_proto_err"}, 128'(proto_err), 128'(v.exp_err));
        chk({nm, "_req_count"}, 128'(req_count), 128'(v.exp_cnt));
    endtask

    initial begin
        int c0;
        int nresp;
        vec_t v;

        //          rd    wr    addr      wdata drop resp  exp_rdata err   cnt
        vt[0]  = '{1'b0, 1'b1, 16'h0040, D0,   0, 1'b1, 128'h0,   1'b0, 16'd1};
        vt[1]  = '{1'b1, 1'b0, 16'h0040, D6,   0, 1'b1, D0,       1'b0, 16'd2};
        vt[2]  = '{1'b0, 1'b1, 16'h004C, D1,   0, 1'b1, 128'h0,   1'b0, 16'd3};
        vt[3]  = '{1'b1, 1'b0, 16'h0040, D6,   0, 1'b1, D1,       1'b0, 16'd4};
        vt[4]  = '{1'b1, 1'b0, 16'h1040, D6,   0, 1'b1, D1,       1'b0, 16'd5};
        vt[5]  = '{1'b1, 1'b0, 16'h0040, D6,   2, 1'b0, 128'h0,   1'b0, 16'd5};
        vt[6]  = '{1'b0, 1'b1, 16'h0040, D2,   3, 1'b0, 128'h0,   1'b0, 16'd5};
        vt[7]  = '{1'b1, 1'b0, 16'h0040, D6,   0, 1'b1, D1,       1'b0, 16'd6};
        vt[8]  = '{1'b1, 1'b1, 16'h0080, D3,   0, 1'b1, 128'h0,   1'b1, 16'd7};
        vt[9]  = '{1'b1, 1'b0, 16'h0080, D6,   0, 1'b1, D3,       1'b1, 16'd8};
        vt[10] = '{1'b0, 1'b1, 16'h0123, D4,   0, 1'b1, 128'h0,   1'b1, 16'd9};
        vt[11] = '{1'b1, 1'b0, 16'h0120, D6,   0, 1'b1, D4,       1'b1, 16'd10};

        rst_n = 1'b0;
        pmem_read = 1'b1; pmem_write = 1'b0; pmem_address = 16'h0040; pmem_wdata = '0;
        p1_read = 1'b0; p1_write = 1'b0; p1_addr = '0; p1_wdata = '0;

        // Reset held with a read pending: nothing may respond.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_resp", 128'(pmem_resp), 128'(0));
            chk("rst_busy", 128'(busy), 128'(0));
            chk("rst_count", 128'(req_count), 128'(0));
        end
        chk("rst_err", 128'(proto_err), 128'(0));
        chk("rst_rdata", pmem_rdata, 128'h0);
        pmem_read = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) apply(vt[i], $sformatf("vec%0d", i));

        // Back-to-back: read held continuously across three responses.
        pmem_read = 1'b1; pmem_address = 16'h0040;
        c0 = cyc;
        sb_q.push_back('{c0 + 4,  1'b1, D1});
        sb_q.push_back('{c0 + 9,  1'b1, D1});
        sb_q.push_back('{c0 + 14, 1'b1, D1});
        nresp = 0;
        for (int k = 1; k <= 30 && nresp < 3; k++) begin
            @(negedge clk);
            if (pmem_resp) nresp++;
        end
        @(negedge clk);
        pmem_read = 1'b0;
        chk("b2b_resp_count", 128'(nresp), 128'(3));
        chk("b2b_req_count", 128'(req_count), 128'(13));

        // Reset in the middle of a write: no commit, statistics cleared.
        pmem_write = 1'b1; pmem_address = 16'h0040; pmem_wdata = D5;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_count", 128'(req_count), 128'(0));
        chk("midrst_err", 128'(proto_err), 128'(0));
        pmem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{1'b1, 1'b0, 16'h0040, D6, 0, 1'b1, D1, 1'b0, 16'd1};
        apply(v, "after_rst");

        // Latency-1 instance: write then read, each answering in cycle 1.
        p1_write = 1'b1; p1_addr = 16'h0200; p1_wdata = D6;
        @(negedge clk);
        chk("l1_wr_resp", 128'(p1_resp), 128'(1));
        @(negedge clk);
        p1_write = 1'b0;
        chk("l1_wr_count", 128'(p1_cnt), 128'(1));
        p1_read = 1'b1;
        @(negedge clk);
        chk("l1_rd_resp", 128'(p1_resp), 128'(1));
        chk("l1_rd_data", p1_rdata, D6);
        @(negedge clk);
        p1_read = 1'b0;
        chk("l1_rd_count", 128'(p1_cnt), 128'(2));

        // Counter wrap: preload near the top, then two held reads.
        force dut1.r_req_count = 16'hFFFE;
        @(negedge clk);
        release dut1.r_req_count;
        p1_read = 1'b1;
        @(negedge clk);
        chk("wrap_resp1", 128'(p1_resp), 128'(1));
        @(negedge clk);
        chk("wrap_dead_cycle", 128'(p1_resp), 128'(0));
        chk("wrap_count_ffff", 128'(p1_cnt), 128'(16'hFFFF));
        @(negedge clk);
        chk("wrap_resp2", 128'(p1_resp), 128'(1));
        @(negedge clk);
        p1_read = 1'b0;
        chk("wrap_count_zero", 128'(p1_cnt), 128'(0));

        repeat (3) @(negedge clk);
        chk("sb_empty", 128'(sb_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
